// File: rtl/dpbuf.sv
// Dual-port word buffer shared by a host port (A) and an SPI-style
// auto-incrementing port (B), with a self-clearing memory after reset
// and a sticky flag for same-address write collisions.
module dpbuf #(
    parameter int data_bits = 8,
    parameter int num_words = 8192,
    parameter int wr_first  = 1,
    parameter int out_reg   = 0,
    localparam int addr_bits = $clog2(num_words)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [addr_bits-1:0] a_addr,
    input  logic [data_bits-1:0] a_wr_val,
    input  logic                 a_wr_en,
    output logic [data_bits-1:0] a_rd_val,
    input  logic [addr_bits-1:0] b_addr,
    input  logic                 b_addr_load,
    input  logic                 b_inc,
    input  logic [data_bits-1:0] b_wr_val,
    input  logic                 b_wr_en,
    output logic [data_bits-1:0] b_rd_val,
    output logic [addr_bits-1:0] b_cur_addr,
    output logic                 busy,
    output logic                 collision,
    input  logic                 collision_clr
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [addr_bits-1:0] last_addr = addr_bits'(num_words - 1);

    logic [data_bits-1:0] mem [num_words];

    state_t               state;
    state_t               state_next;
    logic [addr_bits-1:0] clr_cnt;
    logic [addr_bits-1:0] b_ptr;
    logic [addr_bits-1:0] b_eff;
    logic [addr_bits-1:0] b_ptr_next;
    logic                 coll_hit;
    logic [data_bits-1:0] a_q;
    logic [data_bits-1:0] b_q;

    assign busy       = (state == CLEAR);
    assign b_cur_addr = b_ptr;

    // Port B effective address and the pointer value after this access (wraps at the top)
    always_comb begin
        b_eff      = b_addr_load ? b_addr : b_ptr;
        b_ptr_next = b_eff;
        if (b_inc) begin
            b_ptr_next = (b_eff == last_addr) ? '0 : b_eff + addr_bits'(1);
        end
    end

    // Same-address double write, ignored while the clear sequence owns the memory
    always_comb begin
        coll_hit = !busy && a_wr_en && b_wr_en && (a_addr == b_eff);
    end

    // Clear sequencer next state: leave CLEAR after the last word has been zeroed
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            CLEAR:   if (clr_cnt == last_addr) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // Clear sequencer state register; reset always (re)starts a full clear
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    // Clear address counter, one word per cycle while clearing
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= (clr_cnt == last_addr) ? '0 : clr_cnt + addr_bits'(1);
        end
    end

    // Port B pointer keeps following load/inc even while clearing
    always_ff @(posedge clk) begin
        if (rst) b_ptr <= '0;
        else     b_ptr <= b_ptr_next;
    end

    // Sticky collision flag; a new collision beats a simultaneous clear request
    always_ff @(posedge clk) begin
        if (rst)                collision <= 1'b0;
        else if (coll_hit)      collision <= 1'b1;
        else if (collision_clr) collision <= 1'b0;
    end

    // Memory writes; A is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[clr_cnt] <= '0;
            end else begin
                if (b_wr_en) mem[b_eff]  <= b_wr_val;
                if (a_wr_en) mem[a_addr] <= a_wr_val;
            end
        end
    end

    // First read stage for both ports; a port's own write bypasses when wr_first is set
    always_ff @(posedge clk) begin
        if (rst || busy) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_wr_en && (wr_first != 0)) a_q <= a_wr_val;
            else                            a_q <= mem[a_addr];
            if (b_wr_en && (wr_first != 0)) b_q <= b_wr_val;
            else                            b_q <= mem[b_eff];
        end
    end

    generate
        if (out_reg != 0) begin : g_out_reg
            logic [data_bits-1:0] a_q2;
            logic [data_bits-1:0] b_q2;

            // Optional second read stage, also held at zero during reset and clearing
            always_ff @(posedge clk) begin
                if (rst || busy) begin
                    a_q2 <= '0;
                    b_q2 <= '0;
                end else begin
                    a_q2 <= a_q;
                    b_q2 <= b_q;
                end
            end

            assign a_rd_val = a_q2;
            assign b_rd_val = b_q2;
        end else begin : g_no_out_reg
            assign a_rd_val = a_q;
            assign b_rd_val = b_q;
        end
    endgenerate

endmodule

// File: doc/dpbuf.md
DPBUF -- requirements
Module: dpbuf

Interface
REQ-001 SHALL have parameter data_bits, default 8, the width of each memory word and each data port.
REQ-002 SHALL have parameter num_words, default 8192, the memory depth; legal range is 2 to 65536.
REQ-003 SHALL have parameter wr_first, default 1, the same-port read-during-write mode (1 = new data, 0 = old data).
REQ-004 SHALL have parameter out_reg, default 0, which adds an output pipeline register when set to 1.
REQ-005 SHALL use the derived localparam addr_bits = ceil(log2(num_words)).
REQ-006 SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-007 SHALL have the following ports (name, direction, width, meaning), one per line:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- a_addr  in  addr_bits  host port address
- a_wr_val  in  data_bits  host port write data
- a_wr_en  in  1  host port write strobe
- a_rd_val  out  data_bits  host port read data
- b_addr  in  addr_bits  SPI port address load value
- b_addr_load  in  1  SPI port: access b_addr and load it into the pointer
- b_inc  in  1  SPI port: advance the pointer after this access
- b_wr_val  in  data_bits  SPI port write data
- b_wr_en  in  1  SPI port write strobe
- b_rd_val  out  data_bits  SPI port read data
- b_cur_addr  out  addr_bits  current SPI port pointer
- busy  out  1  memory clear in progress
- collision  out  1  sticky flag: both ports wrote the same address in the same cycle
- collision_clr  in  1  clears collision

Function
REQ-008 SHALL perform one access per port per cycle, with both ports operating concurrently on a single shared memory.
REQ-009 SHALL give read latency of 1 cycle when out_reg=0 and 2 cycles when out_reg=1; the extra stage applies to both ports.
REQ-010 SHALL, on a same-port write with wr_first=1, return the written value on that port's rd_val at normal latency.
REQ-011 SHALL, on a same-port write with wr_first=0, return the prior memory content at that address instead.
REQ-012 SHALL, when one port reads an address that the other port writes in the same cycle, return the old content; no flag is raised.
REQ-013 SHALL define the SPI effective address as b_addr when b_addr_load=1, otherwise b_cur_addr.
REQ-014 SHALL update the SPI pointer as follows:
- next b_cur_addr = effective address + 1 when b_inc=1;
- next b_cur_addr = effective address when b_inc=0;
- the increment wraps from num_words-1 to 0;
- load and inc in the same cycle access b_addr and leave the pointer at b_addr+1.
REQ-015 SHALL, when both ports write the same address in the same cycle, store port A's data, set collision on the next cycle, and hold it until collision_clr or rst.
REQ-016 SHALL give collision set priority over collision_clr when both occur in the same cycle.
REQ-017 SHALL run a clear sequencer with states IDLE and CLEAR:
- rst enters CLEAR with a clear counter of 0;
- CLEAR writes 0 to the address given by the counter and increments the counter, once per cycle;
- after writing address num_words-1, the block moves to IDLE;
- busy=1 exactly while in CLEAR, i.e. for num_words cycles after rst deasserts.
REQ-018 SHALL, while busy=1, ignore a_wr_en and b_wr_en, force both rd_val outputs to 0, suppress collision detection, and still honour pointer load/inc.
REQ-019 SHALL, when rst is asserted during CLEAR, restart the sequence at address 0.

Reset
REQ-020 SHALL, on rst, set a_rd_val=0, b_rd_val=0 (including pipeline registers), b_cur_addr=0, collision=0, and busy=1 from the next cycle.
REQ-021 SHALL not rely on initial blocks for memory contents; the clear sequencer alone defines post-reset memory contents.

Verification
REQ-022 SHALL pass this clear-sequencer scenario: num_words=16 with rst pulsed for 1 cycle -> busy high for exactly 16 cycles, then every address reads 0x00.
REQ-023 SHALL pass this read-during-write scenario: A writes 0x5A to address 3, then the next cycle writes 0xC3 to address 3 while reading -> a_rd_val=0xC3 with wr_first=1, or 0x5A with wr_first=0; with out_reg=1 the same results appear one cycle later.
REQ-024 SHALL pass this pointer-wrap scenario: b_addr_load with b_addr=num_words-2 plus b_inc, then b_inc for 2 cycles writing 0x11, 0x22, 0x33 -> those values land at num_words-2, num_words-1, 0, and b_cur_addr=1.
REQ-025 SHALL pass this collision scenario: A writes 0xAA and B writes 0xBB to address 7 in the same cycle -> address 7 reads 0xAA and collision=1 on the next cycle; collision_clr drops it; simultaneous collision and collision_clr leaves it at 1.
REQ-026 SHALL pass this cross-port scenario: address 9 holds 0x01; A writes 0x02 to address 9 while B reads address 9 -> b_rd_val=0x01 and collision stays 0.
REQ-027 SHALL pass this reset-mid-clear scenario: rst asserted while the clear counter is at 5 -> the counter restarts at 0 and busy lasts num_words more cycles; writes issued while busy have no effect.
